// File: rtl/bus_sram_slave.sv
// Word-addressed, byte-maskable SRAM bus target with a fixed number of wait states
// and an out-of-window error flag.
//  state | meaning
//  IDLE  | ready, a request may be accepted
//  WAIT  | stalling while the counter runs down to 0
//  RESP  | response strobe; ready for a new request in the same cycle
module bus_sram_slave #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [29:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_mask,
  output logic [31:0] resp_data,
  output logic        resp_valid,
  output logic        resp_stall,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [29-ADDR_W:0] BASE_TAG  = BASE_ADDR[31:ADDR_W+2];
  localparam logic [3:0]         WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0]       mem [2**ADDR_W];
  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, hit;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_q, data_q;
  logic              valid_q, err_q, rd_hit_q;

  assign hit        = (req_addr[29:ADDR_W] == BASE_TAG);
  assign idx        = req_addr[ADDR_W-1:0];
  assign resp_stall = (state == WAIT);
  assign accept     = req_en && !resp_stall && !rst;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (accept && WAIT_CYCLES != 0) begin
          state_nxt = WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_hit_q <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      valid_q <= (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == 4'd0);
      if (accept) begin
        err_q    <= !hit;
        rd_hit_q <= hit && !req_we;
      end
      // data_q remembers the last presented response so resp_data holds between strobes
      if (valid_q) data_q <= resp_data;
    end
  end

  // Memory is not reset: a write committed before a reset stays visible afterwards.
  always_ff @(posedge clk) begin
    if (accept && hit) begin
      if (req_we) begin
        for (int i = 0; i < 4; i++) begin
          if (req_mask[i]) mem[idx][8*i +: 8] <= req_data[8*i +: 8];
        end
      end else begin
        rd_q <= mem[idx];
      end
    end
  end

  assign resp_valid = valid_q;
  assign resp_err   = valid_q && err_q;
  assign resp_data  = valid_q ? (rd_hit_q ? rd_q : 32'd0) : data_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Bench for bus_sram_slave: three instances (0, 3 and 4 wait states) checked every cycle
// against a transaction-level model, plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_bus_sram_slave;
  localparam int          NI        = 3;
  localparam int          WC [NI]   = '{0, 3, 4};
  localparam logic [31:0] BA [NI]   = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [31:0] WIN_BYTES = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en     [NI];
  logic        req_we     [NI];
  logic [29:0] req_addr   [NI];
  logic [31:0] req_data   [NI];
  logic [3:0]  req_mask   [NI];
  logic [31:0] resp_data  [NI];
  logic        resp_valid [NI];
  logic        resp_stall [NI];
  logic        resp_err   [NI];

  int          cyc = 0;
  bit          started = 1'b0;
  logic [31:0] mm [NI][16];
  int          acc_at [NI];
  int          resp_at [NI];
  int          free_at [NI];
  logic [31:0] pend_data [NI];
  logic [31:0] last_data [NI];
  logic        pend_err [NI];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_sram_slave #(.ADDR_W(12), .BASE_ADDR(BA[g]), .WAIT_CYCLES(WC[g]), .INIT_FILE("")) dut (
      .clk(clk), .rst(rst),
      .req_en(req_en[g]), .req_we(req_we[g]), .req_addr(req_addr[g]),
      .req_data(req_data[g]), .req_mask(req_mask[g]),
      .resp_data(resp_data[g]), .resp_valid(resp_valid[g]),
      .resp_stall(resp_stall[g]), .resp_err(resp_err[g])
    );
  end

  function automatic logic [29:0] wa_of(int i, int k);
    return 30'(BA[i] >> 2) + 30'(k);
  endfunction

  function automatic logic [29:0] miss_of(int i, int k);
    return (30'(BA[i] >> 2) ^ 30'h0800_0000) + 30'(k);
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, i, cyc, act, exp);
    end
  endtask

  // Transaction-level model: an access accepted at cycle c responds at c+W+1 and
  // stalls the port for cycles c+1..c+W; the response cycle may accept again.
  task automatic model_accept(int i);
    logic [31:0] off;
    int          ix;
    bit          hit;
    off = {req_addr[i], 2'b00} - BA[i];
    hit = off < WIN_BYTES;
    ix  = int'(off >> 2);
    pend_err[i]  = !hit;
    pend_data[i] = '0;
    if (hit && ix < 16) begin
      if (req_we[i]) begin
        for (int b = 0; b < 4; b++)
          if (req_mask[i][b]) mm[i][ix][8*b +: 8] = req_data[i][8*b +: 8];
      end else begin
        pend_data[i] = mm[i][ix];
      end
    end
    acc_at[i]  = cyc;
    resp_at[i] = cyc + WC[i] + 1;
    free_at[i] = resp_at[i];
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          acc_at[i] = -100; resp_at[i] = -1; free_at[i] = 0;
          last_data[i] = '0; pend_data[i] = '0; pend_err[i] = 1'b0;
        end else begin
          if (cyc == resp_at[i]) last_data[i] = pend_data[i];
          if (req_en[i] && cyc >= free_at[i]) model_accept(i);
        end
      end
      if (rst) started = 1'b1;
      cyc++;
    end
  end

  initial begin : compare
    bit v, s;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < NI; i++) begin
          v = (cyc == resp_at[i]);
          s = (cyc > acc_at[i]) && (cyc <= acc_at[i] + WC[i]);
          chk("valid", i, 32'(resp_valid[i]), 32'(v));
          chk("stall", i, 32'(resp_stall[i]), 32'(s));
          chk("err",   i, 32'(resp_err[i]),   32'(v && pend_err[i]));
          chk("data",  i, resp_data[i], v ? pend_data[i] : last_data[i]);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until the slave accepts it.
  task automatic do_req(int i, logic we, logic [29:0] a, logic [31:0] d, logic [3:0] m);
    bit got = 1'b0;
    req_en[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_data[i] = d; req_mask[i] = m;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (!resp_stall[i]) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout inst%0d cyc%0d: got stalled want accepted", i, cyc);
    end
    @(posedge clk);
    #1;
    req_en[i] = 1'b0;
  endtask

  task automatic wait_resp(int i, output logic [31:0] d, output logic e, output int lat);
    bit got = 1'b0;
    d = '0; e = 1'b0; lat = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (resp_valid[i]) begin
        got = 1'b1; d = resp_data[i]; e = resp_err[i]; lat = n;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL resp_timeout inst%0d cyc%0d: got none want resp_valid", i, cyc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] d, cap[$];
    logic        e;
    int          lat, c0, nv, k, capc[$];
    logic [29:0] a;
    for (int i = 0; i < NI; i++) begin
      req_en[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0; req_mask[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_valid", i, 32'(resp_valid[i]), 32'd0);
      chk("rst_stall", i, 32'(resp_stall[i]), 32'd0);
      chk("rst_err",   i, 32'(resp_err[i]),   32'd0);
      chk("rst_data",  i, resp_data[i],       32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 16; j++) do_req(i, 1'b1, wa_of(i, j), $urandom, 4'hF);
    idle(8);

    // write then read the same word on the next cycle, zero wait states
    do_req(0, 1'b1, wa_of(0, 5), 32'hDEAD_BEEF, 4'hF);
    do_req(0, 1'b0, wa_of(0, 5), '0, '0);
    wait_resp(0, d, e, lat);
    chk("raw_data", 0, d, 32'hDEAD_BEEF);
    chk("raw_lat",  0, lat, 1);
    chk("raw_err",  0, 32'(e), 32'd0);

    do_req(0, 1'b1, wa_of(0, 7), 32'h1122_3344, 4'hF);
    do_req(0, 1'b1, wa_of(0, 7), 32'hAABB_CCDD, 4'b0101);
    do_req(0, 1'b0, wa_of(0, 7), '0, '0);
    wait_resp(0, d, e, lat);
    chk("mask_data", 0, d, 32'h11BB_33DD);
    idle(2);

    // three wait states: latency and a request held across the stall
    do_req(1, 1'b0, wa_of(1, 3), '0, '0);
    wait_resp(1, d, e, lat);
    chk("w3_lat", 1, lat, 4);
    do_req(1, 1'b0, wa_of(1, 3), '0, '0);
    c0 = cyc;
    do_req(1, 1'b0, wa_of(1, 4), '0, '0);
    chk("w3_hold_accept", 1, cyc - c0, 4);
    wait_resp(1, d, e, lat);
    chk("w3_hold_lat", 1, lat, 4);

    // out-of-window accesses
    do_req(1, 1'b0, 30'h0800_0000, '0, '0);
    wait_resp(1, d, e, lat);
    chk("miss_err",  1, 32'(e), 32'd1);
    chk("miss_data", 1, d, 32'd0);
    chk("miss_lat",  1, lat, 4);
    do_req(1, 1'b1, 30'h0800_0000, 32'hDEAD_BEEF, 4'hF);
    wait_resp(1, d, e, lat);
    chk("miss_wr_err", 1, 32'(e), 32'd1);
    for (int j = 0; j < 16; j++) do_req(1, 1'b0, wa_of(1, j), '0, '0);
    idle(6);

    // reset while a write is waiting
    do_req(2, 1'b1, wa_of(2, 2), 32'hCAFE_F00D, 4'hF);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstw_stall_pre", 2, 32'(resp_stall[2]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_stall", 2, 32'(resp_stall[2]), 32'd0);
    chk("rstw_data",  2, resp_data[2], 32'd0);
    nv = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (resp_valid[2]) nv++;
    end
    chk("rstw_dropped", 2, nv, 0);
    @(posedge clk); #1;
    do_req(2, 1'b0, wa_of(2, 2), '0, '0);
    wait_resp(2, d, e, lat);
    chk("rstw_kept", 2, d, 32'hCAFE_F00D);
    chk("rstw_lat",  2, lat, 5);

    // back-to-back reads at zero wait states
    for (int j = 0; j < 4; j++) do_req(0, 1'b1, wa_of(0, j), 32'(j), 4'hF);
    idle(3);
    fork
      begin
        for (int j = 0; j < 4; j++) do_req(0, 1'b0, wa_of(0, j), '0, '0);
      end
      begin
        for (int n = 0; n < 7; n++) begin
          @(negedge clk);
          if (resp_valid[0]) begin
            cap.push_back(resp_data[0]);
            capc.push_back(cyc);
          end
        end
      end
    join
    chk("b2b_count", 0, cap.size(), 4);
    if (cap.size() == 4) begin
      for (int j = 0; j < 4; j++) chk("b2b_data", 0, cap[j], 32'(j));
      chk("b2b_span", 0, capc[3] - capc[0], 3);
    end
    idle(4);

    // randomized traffic on each port
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 80; t++) begin
        k = int'($urandom_range(0, 15));
        a = ($urandom_range(0, 7) == 0) ? miss_of(i, k) : wa_of(i, k);
        do_req(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
